// File: rtl/mmio_bus_arbiter_if.sv
// mmio_bus_arbiter_if: two-master MMIO command/response bundle plus the shared slave port
interface mmio_bus_arbiter_if;
    logic        m0_req;
    logic        m0_we;
    logic [3:0]  m0_be;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic [31:0] m0_rdata;
    logic        m0_done;
    logic        m1_req;
    logic        m1_we;
    logic [3:0]  m1_be;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [31:0] m1_rdata;
    logic        m1_done;
    logic        s_we;
    logic [3:0]  s_be;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [31:0] s_rdata;
    logic        busy;
    logic [15:0] m0_cnt;
    logic [15:0] m1_cnt;

    modport slave (
        input  m0_req, m0_we, m0_be, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_be, m1_addr, m1_wdata,
        input  s_rdata,
        output m0_rdata, m0_done, m1_rdata, m1_done,
        output s_we, s_be, s_addr, s_wdata,
        output busy, m0_cnt, m1_cnt
    );

    modport master (
        output m0_req, m0_we, m0_be, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_be, m1_addr, m1_wdata,
        output s_rdata,
        input  m0_rdata, m0_done, m1_rdata, m1_done,
        input  s_we, s_be, s_addr, s_wdata,
        input  busy, m0_cnt, m1_cnt
    );
endinterface

// File: rtl/mmio_bus_arbiter.sv
// mmio_bus_arbiter: serialises two masters onto one MMIO slave port, parking the bus when idle
module mmio_bus_arbiter #(
    parameter logic [31:0] IDLE_ADDR     = 32'h0000_0000,
    parameter bit          M0_FIXED_PRIO = 1'b0
) (
    input logic             clk,
    input logic             rst,
    mmio_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state_q;
    logic        cur_q;
    logic        last_gnt_q;
    logic        s_we_q;
    logic [3:0]  s_be_q;
    logic [31:0] s_addr_q;
    logic [31:0] s_wdata_q;
    logic [31:0] m0_rdata_q;
    logic [31:0] m1_rdata_q;
    logic        m0_done_q;
    logic        m1_done_q;
    logic        busy_q;
    logic [15:0] m0_cnt_q;
    logic [15:0] m1_cnt_q;
    logic        req0_d;
    logic        req1_d;
    logic        gnt_d;
    logic        win_d;

    // Eligible requests: both in IDLE, only the non-completing master in RESP
    always_comb begin
        req0_d = bus.m0_req & ((state_q == IDLE) | ((state_q == RESP) & cur_q));
        req1_d = bus.m1_req & ((state_q == IDLE) | ((state_q == RESP) & ~cur_q));
        gnt_d  = req0_d | req1_d;
        win_d  = req1_d & (~req0_d | (~M0_FIXED_PRIO & ~last_gnt_q));
    end

    // Arbitration FSM; the s_* command defaults back to the parked values every cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cur_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            s_we_q     <= 1'b0;
            s_be_q     <= 4'h0;
            s_addr_q   <= IDLE_ADDR;
            s_wdata_q  <= 32'h0;
            m0_rdata_q <= 32'h0;
            m1_rdata_q <= 32'h0;
            m0_done_q  <= 1'b0;
            m1_done_q  <= 1'b0;
            busy_q     <= 1'b0;
            m0_cnt_q   <= 16'h0;
            m1_cnt_q   <= 16'h0;
        end else begin
            m0_done_q <= 1'b0;
            m1_done_q <= 1'b0;
            s_we_q    <= 1'b0;
            s_be_q    <= 4'h0;
            s_addr_q  <= IDLE_ADDR;
            s_wdata_q <= 32'h0;
            if (state_q == ACCESS) begin
                state_q    <= RESP;
                busy_q     <= 1'b1;
                last_gnt_q <= cur_q;
                if (cur_q) begin
                    m1_done_q <= 1'b1;
                    m1_cnt_q  <= m1_cnt_q + {15'd0, m1_cnt_q != 16'hFFFF};
                    if (!s_we_q) m1_rdata_q <= bus.s_rdata;
                end else begin
                    m0_done_q <= 1'b1;
                    m0_cnt_q  <= m0_cnt_q + {15'd0, m0_cnt_q != 16'hFFFF};
                    if (!s_we_q) m0_rdata_q <= bus.s_rdata;
                end
            end else if (gnt_d) begin
                state_q   <= ACCESS;
                busy_q    <= 1'b1;
                cur_q     <= win_d;
                s_we_q    <= win_d ? bus.m1_we    : bus.m0_we;
                s_be_q    <= win_d ? bus.m1_be    : bus.m0_be;
                s_addr_q  <= win_d ? bus.m1_addr  : bus.m0_addr;
                s_wdata_q <= win_d ? bus.m1_wdata : bus.m0_wdata;
            end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end
        end
    end

    assign bus.s_we     = s_we_q;
    assign bus.s_be     = s_be_q;
    assign bus.s_addr   = s_addr_q;
    assign bus.s_wdata  = s_wdata_q;
    assign bus.m0_rdata = m0_rdata_q;
    assign bus.m1_rdata = m1_rdata_q;
    assign bus.m0_done  = m0_done_q;
    assign bus.m1_done  = m1_done_q;
    assign bus.busy     = busy_q;
    assign bus.m0_cnt   = m0_cnt_q;
    assign bus.m1_cnt   = m1_cnt_q;
endmodule
